ipe: RTL
========

# ipe

Inverse radix-2 butterfly processing element for the real-FFT datapath: exact algebraic inverse of the forward `pe` butterfly. It accepts the four forward-stage outputs plus the same twiddle, and reconstructs the four forward-stage inputs. It adds a valid/ready pipeline, an optional halving step that undoes the forward growth, and a per-frame sample counter with an end-of-frame flag. Inverse stages of the IRFFT chain instantiate it in cascade.

## Interface
- WIDTH, 32: sample width, signed two's complement.
- SHIFT, 16: twiddle fraction bits; twiddle unit magnitude = 2^SHIFT.
- SCALE, 1: 1 = halve each output (exact inverse of forward sums); 0 = no halving, wrap to WIDTH.
- FRAME, 8: butterflies per frame, must be ≥1; drives `out_last`.

Ports:
- Clk  input  1  clock; all logic on rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- in0..in3  input  WIDTH each  forward-stage outputs y0..y3.
- tf  input  2*WIDTH  twiddle; [2W-1:W] = tr, [W-1:0] = ti, signed.
- bypass_n  input  1  0 = y2/y3 are raw differences (no twiddle).
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts beat this cycle.
- out0..out3  output  WIDTH each  reconstructed x0..x3.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- out_last  output  1  marks the last butterfly of a frame.

## Operation
- Transfer on input when in_valid && in_ready. Transfer on output when out_valid && out_ready.
- Pipeline enable: en = !out_valid || out_ready. Tie in_ready = en, combinationally. All three stages advance together when en=1 and all hold when en=0. A stage register loads its valid bit as well as its data.
- **S1** (en): register y0..y3, tr, ti, bypass_n, and v1 = in_valid.
- **S2** (en): compute full 2*WIDTH signed products and register them:
  - pr = y2*tr − y3*ti
  - pi = y2*ti + y3*tr
  - Also register y0, y1, y2, y3, bypass_n, and v2 = v1.
- **S3** (en):
  - d1 = bypass_n ? pr[SHIFT+WIDTH-1:SHIFT] : y2
  - d3 = bypass_n ? −pi[SHIFT+WIDTH-1:SHIFT] : y3, with negation wrapping at WIDTH.
  - Form sums at WIDTH+1 bits: a0 = y0+d1, a1 = y0−d1, a2 = y1+d3, a3 = y1−d3.
  - SCALE=1: outk = ak[WIDTH:1] (arithmetic shift, floor). SCALE=0: outk = ak[WIDTH-1:0].
  - out_valid = v2.
- Frame counter cnt, range 0..FRAME−1:
  - out_last = out_valid && (cnt == FRAME−1).
  - cnt increments on each output transfer and wraps to 0 after the transfer with out_last=1.
- Bubbles (v=0) carry no meaning. Their data registers may load don't-care values; they never change cnt.

## Timing
- Latency 3 cycles from input transfer to out_valid with out_ready held at 1. Throughput 1 beat/cycle.
- Reset (Reset_n=0 at an edge) clears all data registers and valid bits, and sets cnt=0.
  - Outputs after reset: out0..out3=0, out_valid=0, out_last=0. in_ready=1, since out_valid=0.
- Reset mid-operation discards every in-flight beat and restarts the frame count at 0. There is no partial output.
- Stall: when out_valid=1 and out_ready=0, out0..out3, out_valid, out_last and cnt hold stable and in_ready=0. The upstream beat is not consumed.
- A simultaneous output transfer and new input in the same cycle is legal and sustains full rate.
- With no pending output (out_valid=0), the pipeline advances even if out_ready=0. Bubbles collapse.

## Test plan
- Identity twiddle, WIDTH=32, SHIFT=16, SCALE=1: tf=(65536,0), bypass_n=1, in=(14,10,6,−4) → 3 cycles later out=(10,4,7,3), out_valid=1.
- Twiddle −j: tf=(0,−65536), in=(14,10,4,6) → out=(10,4,7,3). Bypass: bypass_n=0, in=(14,10,6,4), tf=garbage → out=(10,4,7,3).
- Back-to-back stream of 20 beats with out_ready=1, FRAME=8 → 20 consecutive outputs, in order. out_last on outputs 8, 16; cnt=4 at end.
- Backpressure: stream while toggling out_ready 1,0,0,1,0,1… → no beat lost or duplicated, outputs stable while stalled, in_ready=0 exactly when out_valid && !out_ready.
- Reset_n=0 for one cycle with 3 beats in flight → next cycle out_valid=0, outs=0, cnt=0. A subsequent frame's first out_last arrives after FRAME new outputs.
- SCALE=0, bypass_n=0, in=(0x7FFFFFFF,0,1,0) → out0 wraps to 0x80000000, out1=0x7FFFFFFE.

Source files
------------

// File: rtl/ipe.sv
// ---------------------------------------------------------------------------
// ipe -- inverse radix-2 butterfly processing element (real-FFT datapath)
//
// Undoes one forward `pe` butterfly: given the forward outputs y0..y3 and
// the same twiddle, it rebuilds the forward inputs x0..x3. The datapath is
// a three-stage valid/ready pipeline that advances as a whole whenever the
// output register is empty or being drained.
//
// Ports
//   Clk, Reset_n        clock (rising edge), synchronous active-low reset
//   in0..in3            forward-stage outputs y0..y3 (signed, WIDTH)
//   tf                  twiddle {tr, ti}, each signed WIDTH, unit = 2^SHIFT
//   bypass_n            0: y2/y3 are raw differences, twiddle ignored
//   in_valid/in_ready   input handshake (in_ready is the pipeline enable)
//   out0..out3          reconstructed x0..x3
//   out_valid/out_ready output handshake
//   out_last            last butterfly of a FRAME-long group
// ---------------------------------------------------------------------------
module ipe #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 16,
    parameter int SCALE = 1,
    parameter int FRAME = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic [WIDTH-1:0]     in3,
    input  logic [2*WIDTH-1:0]   tf,
    input  logic                 bypass_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out0,
    output logic [WIDTH-1:0]     out1,
    output logic [WIDTH-1:0]     out2,
    output logic [WIDTH-1:0]     out3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

    // Whole pipeline moves together: free to advance unless a finished beat
    // is sitting in the output register and downstream refuses it.
    logic en;

    // Stage 1: captured inputs
    logic [WIDTH-1:0]   y_s1_q [4];
    logic [WIDTH-1:0]   y_s1_d [4];
    logic [WIDTH-1:0]   tr_s1_q, tr_s1_d, ti_s1_q, ti_s1_d;
    logic               byp_s1_q, byp_s1_d, v1_q, v1_d;

    // Stage 2: full-width twiddle products plus passthrough
    logic [2*WIDTH-1:0] y2_x, y3_x, tr_x, ti_x;
    logic [2*WIDTH-1:0] pr_q, pr_d, pi_q, pi_d;
    logic [WIDTH-1:0]   y_s2_q [4];
    logic [WIDTH-1:0]   y_s2_d [4];
    logic               byp_s2_q, byp_s2_d, v2_q, v2_d;

    // Stage 3: reconstructed samples and frame position
    logic [WIDTH-1:0]   d1, d3;
    logic [WIDTH-1:0]   sum_res [4];
    logic [WIDTH-1:0]   out_q [4];
    logic [WIDTH-1:0]   out_d [4];
    logic               out_valid_q, out_valid_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin : s1_next
        y_s1_d   = y_s1_q;
        tr_s1_d  = tr_s1_q;
        ti_s1_d  = ti_s1_q;
        byp_s1_d = byp_s1_q;
        v1_d     = v1_q;
        if (en) begin
            y_s1_d[0] = in0;
            y_s1_d[1] = in1;
            y_s1_d[2] = in2;
            y_s1_d[3] = in3;
            tr_s1_d   = tf[2*WIDTH-1:WIDTH];
            ti_s1_d   = tf[WIDTH-1:0];
            byp_s1_d  = bypass_n;
            v1_d      = in_valid;
        end
    end

    // Sign-extend to 2*WIDTH so the low 2*WIDTH bits of each product are the
    // exact signed result.
    assign y2_x = {{WIDTH{y_s1_q[2][WIDTH-1]}}, y_s1_q[2]};
    assign y3_x = {{WIDTH{y_s1_q[3][WIDTH-1]}}, y_s1_q[3]};
    assign tr_x = {{WIDTH{tr_s1_q[WIDTH-1]}}, tr_s1_q};
    assign ti_x = {{WIDTH{ti_s1_q[WIDTH-1]}}, ti_s1_q};

    always_comb begin : s2_next
        pr_d     = pr_q;
        pi_d     = pi_q;
        y_s2_d   = y_s2_q;
        byp_s2_d = byp_s2_q;
        v2_d     = v2_q;
        if (en) begin
            pr_d     = y2_x * tr_x - y3_x * ti_x;
            pi_d     = y2_x * ti_x + y3_x * tr_x;
            y_s2_d   = y_s1_q;
            byp_s2_d = byp_s1_q;
            v2_d     = v1_q;
        end
    end

    // Drop the twiddle fraction bits; the imaginary part is negated (conjugate
    // rotation) with wrap at WIDTH.
    assign d1 = byp_s2_q ? WIDTH'(pr_q >> SHIFT) : y_s2_q[2];
    assign d3 = byp_s2_q ? (WIDTH'(0) - WIDTH'(pi_q >> SHIFT)) : y_s2_q[3];

    // Even outputs are sums, odd outputs differences; one guard bit keeps the
    // halved result exact before the floor shift.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sum
            logic [WIDTH:0] base_x, term_x, acc;
            assign base_x = (gi < 2) ? {y_s2_q[0][WIDTH-1], y_s2_q[0]}
                                     : {y_s2_q[1][WIDTH-1], y_s2_q[1]};
            assign term_x = (gi < 2) ? {d1[WIDTH-1], d1} : {d3[WIDTH-1], d3};
            assign acc    = (gi % 2 == 0) ? (base_x + term_x) : (base_x - term_x);
            assign sum_res[gi] = (SCALE != 0) ? acc[WIDTH:1] : acc[WIDTH-1:0];
        end
    endgenerate

    always_comb begin : s3_next
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_d       = sum_res;
            out_valid_d = v2_q;
        end
    end

    // Only real output transfers move the frame position.
    always_comb begin : cnt_next
        cnt_d = cnt_q;
        if (out_valid_q && out_ready) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int k = 0; k < 4; k++) begin
                y_s1_q[k] <= '0;
                y_s2_q[k] <= '0;
                out_q[k]  <= '0;
            end
            tr_s1_q     <= '0;
            ti_s1_q     <= '0;
            byp_s1_q    <= 1'b0;
            v1_q        <= 1'b0;
            pr_q        <= '0;
            pi_q        <= '0;
            byp_s2_q    <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            y_s1_q      <= y_s1_d;
            y_s2_q      <= y_s2_d;
            out_q       <= out_d;
            tr_s1_q     <= tr_s1_d;
            ti_s1_q     <= ti_s1_d;
            byp_s1_q    <= byp_s1_d;
            v1_q        <= v1_d;
            pr_q        <= pr_d;
            pi_q        <= pi_d;
            byp_s2_q    <= byp_s2_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q && (cnt_q == LAST_CNT);

endmodule
